// File: rtl/sign_image_gen.sv
// sign_image_gen: raster test-pattern source drawing a palm plus raised-finger rectangles for a 4-bit sign code
//   clk, rst            pixel clock, asynchronous active-high reset
//   run                 level, 1 = generate back-to-back frames
//   sign_value/valid    code strobe into the pending register
//   de_t, object_image  active-video qualifier and hand mask pixel
//   pix_x, pix_y        position described by de_t/object_image
//   frame_start/done    pulses at raster (0,0) and (H_TOTAL-1,V_TOTAL-1)
//   finger_mask         {thumb,index,middle,ring,pinky} drawn this frame
//   sign_invalid, busy  active code was 10..15; frame in progress
module sign_image_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_TOTAL    = 800,
    parameter int V_ACTIVE   = 480,
    parameter int V_TOTAL    = 525,
    parameter int PALM_X0    = 270,
    parameter int PALM_Y0    = 240,
    parameter int PALM_W     = 100,
    parameter int PALM_H     = 50,
    parameter int FINGER_W   = 12,
    parameter int FINGER_LEN = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] sign_value,
    input  logic       sign_valid,
    output logic       de_t,
    output logic       object_image,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       frame_start,
    output logic       frame_done,
    output logic [4:0] finger_mask,
    output logic       sign_invalid,
    output logic       busy
);
    localparam int Q   = PALM_W / 4;
    localparam int OFF = (Q - FINGER_W) / 2;
    localparam logic [9:0] HA   = 10'(H_ACTIVE);
    localparam logic [9:0] HT   = 10'(H_TOTAL - 1);
    localparam logic [9:0] VA   = 10'(V_ACTIVE);
    localparam logic [9:0] VT   = 10'(V_TOTAL - 1);
    localparam logic [9:0] PX_L = 10'(PALM_X0);
    localparam logic [9:0] PX_R = 10'(PALM_X0 + PALM_W - 1);
    localparam logic [9:0] PY_T = 10'(PALM_Y0);
    localparam logic [9:0] PY_B = 10'(PALM_Y0 + PALM_H - 1);
    localparam logic [9:0] FY_T = 10'(PALM_Y0 - FINGER_LEN);
    localparam logic [9:0] FY_B = 10'(PALM_Y0 - 1);
    localparam logic [9:0] TX_L = 10'(PALM_X0 - FINGER_LEN);
    localparam logic [9:0] TX_R = 10'(PALM_X0 - 1);
    localparam logic [9:0] TY_B = 10'(PALM_Y0 + FINGER_W - 1);

    typedef enum logic {IDLE, SCAN} state_t;
    state_t r_state, w_next;
    logic [9:0] r_h, r_v;
    logic [3:0] r_pend, r_act;
    logic       w_scan, w_last, w_load, w_de, w_obj, w_palm, w_fy, w_thumb;
    logic [3:0] w_fx;
    logic [4:0] w_fm;

    assign w_scan = r_state == SCAN;
    assign w_last = w_scan && r_h == HT && r_v == VT;
    // Active code changes only on the edge that moves the counters onto (0,0) of a new frame
    assign w_load = run && (!w_scan || w_last);

    always_comb begin
        w_next = r_state;
        w_next = w_scan ? ((w_last && !run) ? IDLE : SCAN) : (run ? SCAN : IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_h     <= '0;
            r_v     <= '0;
            r_pend  <= '0;
            r_act   <= '0;
        end else begin
            r_state <= w_next;
            if (!w_scan || w_last) begin
                r_h <= '0;
                r_v <= '0;
            end else if (r_h == HT) begin
                r_h <= '0;
                r_v <= r_v + 10'd1;
            end else begin
                r_h <= r_h + 10'd1;
            end
            if (sign_valid) r_pend <= sign_value;
            // A strobe landing on the copy edge goes straight into the new frame
            if (w_load) r_act <= sign_valid ? sign_value : r_pend;
        end
    end

    always_comb begin
        w_fm = 5'b00000;
        case (r_act)
            4'd1:    w_fm = 5'b01000;
            4'd2:    w_fm = 5'b01100;
            4'd3:    w_fm = 5'b01110;
            4'd4:    w_fm = 5'b01111;
            4'd5:    w_fm = 5'b11111;
            4'd6:    w_fm = 5'b11000;
            4'd7:    w_fm = 5'b10001;
            4'd8:    w_fm = 5'b00111;
            4'd9:    w_fm = 5'b10000;
            default: w_fm = 5'b00000;
        endcase
    end

    genvar k;
    for (k = 1; k <= 4; k++) begin : g_f
        localparam logic [9:0] L = 10'(PALM_X0 + (k - 1) * Q + OFF);
        localparam logic [9:0] R = 10'(PALM_X0 + (k - 1) * Q + OFF + FINGER_W - 1);
        assign w_fx[4-k] = r_h >= L && r_h <= R;
    end

    assign w_de    = w_scan && r_h < HA && r_v < VA;
    assign w_palm  = r_act < 4'd10 && r_h >= PX_L && r_h <= PX_R && r_v >= PY_T && r_v <= PY_B;
    assign w_fy    = r_v >= FY_T && r_v <= FY_B;
    assign w_thumb = w_fm[4] && r_h >= TX_L && r_h <= TX_R && r_v >= PY_T && r_v <= TY_B;
    assign w_obj   = w_de && (w_palm || w_thumb || (w_fy && |(w_fx & w_fm[3:0])));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_t         <= 1'b0;
            object_image <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
            finger_mask  <= '0;
            sign_invalid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            de_t         <= w_de;
            object_image <= w_obj;
            pix_x        <= r_h;
            pix_y        <= r_v;
            frame_start  <= w_scan && r_h == 10'd0 && r_v == 10'd0;
            frame_done   <= w_last;
            finger_mask  <= w_fm;
            sign_invalid <= r_act > 4'd9;
            busy         <= w_scan;
        end
    end
endmodule

// File: tb/tb_sign_image_gen.sv
// tb_sign_image_gen: directed checks of sign_image_gen on a reduced raster geometry
module tb_sign_image_gen;
    localparam int HA = 40, HT = 48, VA = 30, VT = 34;

    logic       clk = 1'b0, rst = 1'b1, run = 1'b0, sign_valid = 1'b0;
    logic [3:0] sign_value = '0;
    logic       de_t, object_image, frame_start, frame_done, sign_invalid, busy;
    logic [9:0] pix_x, pix_y;
    logic [4:0] finger_mask;

    sign_image_gen #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
        .PALM_X0(14), .PALM_Y0(14), .PALM_W(16), .PALM_H(6),
        .FINGER_W(3), .FINGER_LEN(8)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .sign_value(sign_value), .sign_valid(sign_valid),
        .de_t(de_t), .object_image(object_image), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .frame_done(frame_done), .finger_mask(finger_mask),
        .sign_invalid(sign_invalid), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int m_obj = 0, m_de = 0, m_cyc = 0, m_leak = 0, done_cnt = 0;
    int l_obj = 0, l_de = 0, l_cyc = 0;
    logic [4:0] l_fm = '0;
    logic l_inv = 1'b0;
    logic img [0:VT-1][0:HT-1];

    always @(negedge clk) begin
        if (frame_start) begin
            m_obj = 0;
            m_de  = 0;
            m_cyc = 0;
        end
        m_cyc++;
        if (de_t) begin
            m_de++;
            if (object_image) m_obj++;
            img[pix_y][pix_x] = object_image;
        end
        if (object_image && !de_t) m_leak++;
        if (frame_done) begin
            l_obj = m_obj;
            l_de  = m_de;
            l_cyc = m_cyc;
            l_fm  = finger_mask;
            l_inv = sign_invalid;
            done_cnt++;
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic wait_done(input int n);
        int tgt = done_cnt + n;
        int t = 0;
        while (done_cnt < tgt && t < 2500 * n) begin
            @(posedge clk);
            t++;
        end
        chk("frame_done_timeout", done_cnt >= tgt, 1);
    endtask

    task automatic wait_row(input int y);
        int t = 0;
        while (pix_y != 10'(y) && t < 2500) begin
            @(posedge clk);
            t++;
        end
        chk("row_timeout", pix_y == 10'(y), 1);
    endtask

    task automatic strobe(input logic [3:0] c);
        @(posedge clk);
        #1 sign_value = c;
        sign_valid = 1'b1;
        @(posedge clk);
        #1 sign_valid = 1'b0;
    endtask

    typedef struct {
        logic [3:0] code;
        int         cnt;
        logic [4:0] fm;
        logic       inv;
        int         x1, y1;
        logic       v1;
        int         x2, y2;
        logic       v2;
    } vec_t;

    vec_t vt [11];

    initial begin
        int acc;
        vt[0]  = '{4'd0,  96,  5'b00000, 1'b0, 14, 14, 1'b1, 30, 19, 1'b0};
        vt[1]  = '{4'd0,  96,  5'b00000, 1'b0, 29, 19, 1'b1, 14, 13, 1'b0};
        vt[2]  = '{4'd1,  120, 5'b01000, 1'b0, 15, 6,  1'b1, 15, 5,  1'b0};
        vt[3]  = '{4'd1,  120, 5'b01000, 1'b0, 16, 13, 1'b1, 18, 10, 1'b0};
        vt[4]  = '{4'd2,  144, 5'b01100, 1'b0, 20, 10, 1'b1, 22, 10, 1'b0};
        vt[5]  = '{4'd4,  192, 5'b01111, 1'b0, 28, 8,  1'b1, 29, 8,  1'b0};
        vt[6]  = '{4'd6,  144, 5'b11000, 1'b0, 13, 16, 1'b1, 13, 17, 1'b0};
        vt[7]  = '{4'd7,  144, 5'b10001, 1'b0, 27, 13, 1'b1, 15, 10, 1'b0};
        vt[8]  = '{4'd8,  168, 5'b00111, 1'b0, 22, 6,  1'b1, 15, 10, 1'b0};
        vt[9]  = '{4'd9,  120, 5'b10000, 1'b0, 6,  14, 1'b1, 5,  15, 1'b0};
        vt[10] = '{4'd12, 0,   5'b00000, 1'b1, 20, 16, 1'b0, 15, 10, 1'b0};

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {de_t, object_image, pix_x, pix_y, frame_start, frame_done,
                              finger_mask, sign_invalid, busy}, 0);
        #1 rst = 1'b0;
        acc = 0;
        repeat (50) begin
            @(negedge clk);
            if ({de_t, object_image, pix_x, pix_y, frame_start, frame_done, finger_mask,
                 sign_invalid, busy} != 0) acc++;
        end
        chk("idle_outputs_zero", acc, 0);

        strobe(4'd5);
        #1 run = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("first_frame_start", frame_start, 1);
        chk("first_pix", {pix_x, pix_y}, 0);
        chk("first_busy", busy, 1);
        wait_done(1);
        chk("c5_count", l_obj, 216);
        chk("c5_cycles", l_cyc, HT * VT);
        chk("c5_de", l_de, HA * VA);
        chk("c5_mask", l_fm, 5'b11111);
        chk("c5_index", img[10][15], 1);
        chk("c5_thumb", img[15][6], 1);
        chk("c5_gap", img[10][17], 0);

        for (int i = 0; i < 11; i++) begin
            strobe(vt[i].code);
            wait_done(2);
            chk($sformatf("v%0d_count", i), l_obj, vt[i].cnt);
            chk($sformatf("v%0d_mask", i), l_fm, vt[i].fm);
            chk($sformatf("v%0d_inv", i), l_inv, vt[i].inv);
            chk($sformatf("v%0d_de", i), l_de, HA * VA);
            chk($sformatf("v%0d_p1", i), img[vt[i].y1][vt[i].x1], vt[i].v1);
            chk($sformatf("v%0d_p2", i), img[vt[i].y2][vt[i].x2], vt[i].v2);
        end

        strobe(4'd3);
        wait_done(2);
        wait_row(2);
        strobe(4'd2);
        wait_done(1);
        chk("mid_old_mask", l_fm, 5'b01110);
        chk("mid_old_ring", img[10][22], 1);
        chk("mid_old_count", l_obj, 168);
        wait_done(1);
        chk("mid_new_mask", l_fm, 5'b01100);
        chk("mid_new_ring", img[10][22], 0);
        chk("mid_new_count", l_obj, 144);

        wait_row(5);
        #1 run = 1'b0;
        wait_done(1);
        chk("stop_full_frame", l_cyc, HT * VT);
        @(negedge clk);
        chk("stop_busy", busy, 0);
        acc = 0;
        repeat (30) begin
            @(negedge clk);
            if (de_t || busy || frame_start) acc++;
        end
        chk("stop_stays_idle", acc, 0);

        #1 run = 1'b1;
        wait_row(12);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_busy", busy, 0);
        chk("rst_async_pix", {pix_x, pix_y}, 0);
        chk("rst_async_mask", finger_mask, 0);
        chk("rst_async_de", de_t, 0);
        run = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("no_obj_outside_de", m_leak, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
